// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: receive-side button handler. Raw button levels are
// synchronised, debounced and edge-detected; each press is queued as a 3-bit
// button code in a small FIFO that the CPU polls and pops through a
// single-cycle read/pop port.
//
// Optional feature: define BTN_EVENT_IRQ_EN to add a registered irq output
// that rises when the FIFO becomes non-empty or an event is lost, and falls
// when a pop leaves the FIFO empty with overflow clear.
//
// CPU port handshake: rd_en and pop_en are single-cycle strobes with no
// ready/stall; rd_data captures the pre-edge status on the rd_en edge, and a
// pop on an empty FIFO is ignored (it still clears overflow).

module btn_event_ctrl #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               rd_en,
  input  logic               pop_en,
  output logic [31:0]        rd_data,
  output logic [NUM_BTN-1:0] btn_state,
  output logic               ev_valid
`ifdef BTN_EVENT_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [DCW-1:0] DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);

  // Synchroniser and debounce state
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [DCW-1:0]     db_cnt_q [NUM_BTN];
  logic [DCW-1:0]     db_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] state_q;
  logic [NUM_BTN-1:0] state_d;

  // Press tracking
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pend_q;
  logic [NUM_BTN-1:0] pend_d;
  logic [NUM_BTN-1:0] push_mask;
  logic               collision;
  logic               ovf_q;
  logic               ovf_d;

  // Event FIFO
  logic [2:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW-1:0]      rd_ptr_d;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop_fire;
  logic               push;
  logic               push_found;
  logic [2:0]         push_idx;
  logic [2:0]         head_code;

  // CPU status word
  logic [31:0]        rd_data_q;
  logic [31:0]        rd_data_d;
  logic [7:0]         state_field;
  logic [3:0]         count_field;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign pop_fire   = pop_en & ~fifo_empty;
  assign head_code  = fifo_empty ? 3'd0 : mem_q[rd_ptr_q];

  // Two-flop synchroniser on every raw button line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles where the synced level disagrees with
  // the accepted level; accept the change on the DEBOUNCE_CYCLES-th such cycle
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == state_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        state_d[i]  = ~state_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DCW'(1);
      end
    end
  end

  // Debounce counters and accepted button levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // A press is a 0->1 change of the accepted level; releases are ignored
  assign rise      = state_d & ~state_q;
  assign collision = |(rise & pend_q);

  // Pick the lowest pending button; it is pushed when a slot is free, which
  // includes the full case when a pop retires the head on the same edge
  always_comb begin
    push_found = 1'b0;
    push_idx   = 3'd0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!push_found && pend_q[i]) begin
        push_found = 1'b1;
        push_idx   = 3'(i);
      end
    end
  end

  assign push = push_found & (~fifo_full | pop_fire);

  // Pending and overflow next state; a new press on a still-pending button
  // is the only source of overflow, and a set beats a pop-driven clear
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      push_mask[i] = push && (push_idx == 3'(i));
    end
    pend_d = (pend_q & ~push_mask) | rise;
    ovf_d  = collision | (ovf_q & ~pop_en);
  end

  // Pending presses and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // FIFO pointer and occupancy next state
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 3'd0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_idx;
      end
    end
  end

  // Status word assembled from pre-edge state; it is only captured on rd_en
  assign state_field = 8'(state_q);
  assign count_field = 4'(count_q);

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = {15'd0, ovf_q, count_field, ~fifo_empty, head_code, state_field};
    end
  end

  // Registered CPU read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign btn_state = state_q;
  assign ev_valid  = ~fifo_empty;

`ifdef BTN_EVENT_IRQ_EN
  logic irq_q;
  logic irq_d;

  // Raise on empty->non-empty or a lost event; drop once a pop drains the
  // FIFO with overflow clear; a raise on the same edge wins
  always_comb begin
    irq_d = irq_q;
    if (pop_en && (count_d == '0) && !ovf_d) begin
      irq_d = 1'b0;
    end
    if ((fifo_empty && (count_d != '0)) || collision) begin
      irq_d = 1'b1;
    end
  end

  // Interrupt request register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule
